// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment AXI4-Lite controller:
// register map, CTRL fields, AXI response codes and the hex font.
package seg7_pkg;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_DATA = 2'd1;
    localparam logic [1:0] REG_DP   = 2'd2;
    localparam logic [1:0] REG_DIV  = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_DUTY_LSB = 8;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_AW,
        WR_W,
        WR_RESP
    } wr_state_t;

    // Active-high segment pattern, a..g on bit0..bit6
    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] wmerge(
        input logic [31:0] old,
        input logic [31:0] nxt,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = strb[b] ? nxt[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/seg7_axil_slave_scan.sv
// Digit scanner: prescaler, digit counter, font decode, output registers.
// Optional brightness gate on the anodes when SEG7_PWM_DIM_EN is defined.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [31:0]             div,
    input  logic                    div_wr,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
`ifdef SEG7_PWM_DIM_EN
    input  logic [3:0]              duty,
`endif
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

    logic [31:0]   pre;
    logic [IW-1:0] idx;
    logic [3:0]    nib;
    logic          dpb;
    logic          on;

    always_comb begin
        nib = '0;
        dpb = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib = data[4*i +: 4];
                dpb = dp[i];
            end
        end
    end

`ifdef SEG7_PWM_DIM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm_cnt <= '0;
        else     pwm_cnt <= pwm_cnt + 4'd1;
    end

    assign on = (pwm_cnt <= duty);
`else
    assign on = 1'b1;
`endif

    // >= rather than == so lowering the divisor never strands the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
        end else if (div_wr) begin
            pre <= '0;
        end else if (pre >= div) begin
            pre <= '0;
            idx <= (idx == LAST) ? '0 : idx + 1'b1;
        end else begin
            pre <= pre + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_n <= '1;
            dp_n  <= 1'b1;
            an_n  <= '1;
        end else if (!en) begin
            seg_n <= '1;
            dp_n  <= 1'b1;
            an_n  <= '1;
        end else begin
            seg_n <= ~hex2seg(nib);
            dp_n  <= ~dpb;
            an_n  <= on ? ~(NUM_DIGITS'(1) << idx) : '1;
        end
    end

endmodule

// File: rtl/seg7_axil_slave.sv
// AXI4-Lite register file for the 7-segment controller plus scan driver.
// Define SEG7_PWM_DIM_EN to enable anode dimming from CTRL[11:8].
module seg7_axil_slave
    import seg7_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int NUM_DIGITS  = 4,
    parameter int DEFAULT_DIV = 50000
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] an_n
);

    logic [31:0] ctrl_q, data_q, dp_q, div_q;
    wr_state_t   wr_st, wr_nxt;
    logic [1:0]  aw_idx;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        aw_hs, w_hs, ar_hs, do_wr;
    logic [1:0]  wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [31:0] rd_val;
    logic        unused_ok;

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot,
                         s_axi_awaddr, s_axi_araddr};

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;

    // Either half may already be latched or arriving on this edge
    assign do_wr   = (aw_hs | wr_st == WR_AW) & (w_hs | wr_st == WR_W);
    assign wr_idx  = (wr_st == WR_AW) ? aw_idx : s_axi_awaddr[3:2];
    assign wr_data = (wr_st == WR_W) ? w_data : s_axi_wdata;
    assign wr_strb = (wr_st == WR_W) ? w_strb : s_axi_wstrb;

    assign s_axi_bresp = RESP_OKAY;
    assign s_axi_rresp = RESP_OKAY;

    always_comb begin
        wr_nxt = wr_st;
        unique case (wr_st)
            WR_IDLE: begin
                if (do_wr)      wr_nxt = WR_RESP;
                else if (aw_hs) wr_nxt = WR_AW;
                else if (w_hs)  wr_nxt = WR_W;
            end
            WR_AW:   if (w_hs) wr_nxt = WR_RESP;
            WR_W:    if (aw_hs) wr_nxt = WR_RESP;
            WR_RESP: if (s_axi_bready) wr_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_st         <= WR_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            aw_idx        <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            ctrl_q        <= '0;
            data_q        <= '0;
            dp_q          <= '0;
            div_q         <= 32'(DEFAULT_DIV);
        end else begin
            wr_st         <= wr_nxt;
            s_axi_awready <= (wr_nxt == WR_IDLE) | (wr_nxt == WR_W);
            s_axi_wready  <= (wr_nxt == WR_IDLE) | (wr_nxt == WR_AW);
            s_axi_bvalid  <= (wr_nxt == WR_RESP);
            if (aw_hs) aw_idx <= s_axi_awaddr[3:2];
            if (w_hs) begin
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            if (do_wr) begin
                unique case (wr_idx)
                    REG_CTRL: ctrl_q <= wmerge(ctrl_q, wr_data, wr_strb);
                    REG_DATA: data_q <= wmerge(data_q, wr_data, wr_strb);
                    REG_DP:   dp_q   <= wmerge(dp_q, wr_data, wr_strb);
                    REG_DIV:  div_q  <= wmerge(div_q, wr_data, wr_strb);
                endcase
            end
        end
    end

    always_comb begin
        rd_val = '0;
        unique case (s_axi_araddr[3:2])
            REG_CTRL: rd_val = ctrl_q;
            REG_DATA: rd_val = data_q;
            REG_DP:   rd_val = dp_q;
            REG_DIV:  rd_val = div_q;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
        end else begin
            s_axi_arready <= ~(ar_hs | (s_axi_rvalid & ~s_axi_rready));
            if (ar_hs) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_val;
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    seg7_scan #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_scan (
        .clk    (ACLK),
        .rst    (ARESET),
        .en     (ctrl_q[CTRL_EN]),
        .div    (div_q),
        .div_wr (do_wr && wr_idx == REG_DIV),
        .data   (data_q[4*NUM_DIGITS-1:0]),
        .dp     (dp_q[NUM_DIGITS-1:0]),
`ifdef SEG7_PWM_DIM_EN
        .duty   (ctrl_q[CTRL_DUTY_LSB +: 4]),
`endif
        .seg_n  (seg_n),
        .dp_n   (dp_n),
        .an_n   (an_n)
    );

endmodule
